// File: rtl/ram_pkg.sv
// Shared types and constants for the DRAM sequencer/arbiter.
package ram_pkg;

  localparam int unsigned CntW            = 3;
  localparam int unsigned PreCyclesDef    = 2;
  localparam int unsigned RefRasCyclesDef = 3;
  localparam int unsigned CyclesMin       = 1;
  localparam int unsigned CyclesMax       = 7;

  typedef enum logic [2:0] {
    StIdle,
    StRas,
    StCas,
    StHold,
    StPre,
    StRcas,
    StRras,
    StRpre
  } ram_state_e;

  // Counter load value for a phase lasting `cycles` cycles, clamped to the legal range.
  function automatic logic [CntW-1:0] cnt_load(int unsigned cycles);
    int unsigned c;
    c = (cycles < CyclesMin) ? CyclesMin : ((cycles > CyclesMax) ? CyclesMax : cycles);
    return CntW'(c - 1);
  endfunction

endpackage

// File: rtl/ram_delay_cnt.sv
// Loadable 3-bit down-counter with zero flag; holds at zero instead of wrapping.
module ram_delay_cnt
  import ram_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            zero
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ram_arbiter.sv
// DRAM sequencer: arbitrates CPU accesses against CBR refresh and drives RAS/CAS/mux.
// Define RAM_REFSTAT_EN to add the RefCount/UrgentCount statistics outputs.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned PRE_CYCLES     = PreCyclesDef,
  parameter int unsigned REF_RAS_CYCLES = RefRasCyclesDef
) (
  input  logic        FCLK,
  input  logic        nRESET,
  input  logic        ASActive,
  input  logic        ASInactive,
  input  logic        RAMCS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        RefReq,
  input  logic        RefUrgent,
  output logic        nRAS,
  output logic        nCASH,
  output logic        nCASL,
  output logic        RASMux,
  output logic        RAMReady,
  output logic        RefAck,
  output logic        Busy
`ifdef RAM_REFSTAT_EN
  ,
  output logic [15:0] RefCount,
  output logic [7:0]  UrgentCount
`endif
);

  localparam logic [CntW-1:0] PreLoad = cnt_load(PRE_CYCLES);
  localparam logic [CntW-1:0] RefLoad = cnt_load(REF_RAS_CYCLES);

  ram_state_e      state_q, state_d;
  logic            cnt_load_en;
  logic [CntW-1:0] cnt_load_val;
  logic            cnt_zero;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (RefUrgent)               state_d = StRcas;
        else if (ASActive && RAMCS)  state_d = StRas;
        else if (RefReq)             state_d = StRcas;
      end
      StRas:         state_d = ASInactive ? StPre : StCas;
      StCas, StHold: state_d = ASInactive ? StPre : StHold;
      StPre:         if (cnt_zero) state_d = StIdle;
      StRcas:        state_d = StRras;
      StRras:        if (cnt_zero) state_d = StRpre;
      StRpre:        if (cnt_zero) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // Every timed phase loads the counter on entry and leaves once it reads zero.
  assign cnt_load_en  = (state_d != state_q) &&
                        (state_d == StPre || state_d == StRras || state_d == StRpre);
  assign cnt_load_val = (state_d == StRras) ? RefLoad : PreLoad;

  ram_delay_cnt u_delay_cnt (
    .clk      (FCLK),
    .rst_n    (nRESET),
    .load     (cnt_load_en),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // Outputs are registered from the next state so they change on the deciding edge.
  always_ff @(posedge FCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= StIdle;
      nRAS     <= 1'b1;
      nCASH    <= 1'b1;
      nCASL    <= 1'b1;
      RASMux   <= 1'b0;
      RAMReady <= 1'b0;
      RefAck   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      nRAS     <= 1'b1;
      nCASH    <= 1'b1;
      nCASL    <= 1'b1;
      RASMux   <= 1'b0;
      RAMReady <= 1'b0;
      RefAck   <= (state_q == StRcas);
      Busy     <= (state_d != StIdle);
      case (state_d)
        StRas: nRAS <= 1'b0;
        StCas, StHold: begin
          nRAS     <= 1'b0;
          nCASH    <= nUDS;
          nCASL    <= nLDS;
          RASMux   <= 1'b1;
          RAMReady <= 1'b1;
        end
        StRcas: begin
          nCASH <= 1'b0;
          nCASL <= 1'b0;
        end
        StRras:  nRAS <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef RAM_REFSTAT_EN
  always_ff @(posedge FCLK or negedge nRESET) begin
    if (!nRESET) begin
      RefCount    <= '0;
      UrgentCount <= '0;
    end else begin
      if (state_q == StRcas && RefCount != 16'hFFFF) begin
        RefCount <= RefCount + 16'd1;
      end
      if (state_q == StIdle && RefUrgent && UrgentCount != 8'hFF) begin
        UrgentCount <= UrgentCount + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised bench for ram_arbiter against a schedule-based reference model.
module tb_ram_arbiter;

  localparam int unsigned Pre = 2;
  localparam int unsigned Ref = 3;

  // Output vector packing: {nRAS, nCASH, nCASL, RASMux, RAMReady, RefAck, Busy}
  localparam logic [6:0] VIdle   = 7'b1110000;
  localparam logic [6:0] VRas    = 7'b0110001;
  localparam logic [6:0] VPre    = 7'b1110001;
  localparam logic [6:0] VRcas   = 7'b1000001;
  localparam logic [6:0] VRrasAk = 7'b0110011;
  localparam logic [6:0] VRras   = 7'b0110001;

  logic fclk = 1'b0;
  logic n_reset, as_active, as_inactive, ramcs, n_uds, n_lds, ref_req, ref_urgent;
  logic n_ras, n_cash, n_casl, ras_mux, ram_ready, ref_ack, busy;
`ifdef RAM_REFSTAT_EN
  logic [15:0] ref_count;
  logic [7:0]  urgent_count;
  int unsigned m_ref_cnt, m_urg_cnt;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [6:0] sched[$];
  bit         in_acc;
  logic [6:0] exp_v;

  always #5 fclk = ~fclk;

  ram_arbiter #(
    .PRE_CYCLES     (Pre),
    .REF_RAS_CYCLES (Ref)
  ) dut (
    .FCLK       (fclk),
    .nRESET     (n_reset),
    .ASActive   (as_active),
    .ASInactive (as_inactive),
    .RAMCS      (ramcs),
    .nUDS       (n_uds),
    .nLDS       (n_lds),
    .RefReq     (ref_req),
    .RefUrgent  (ref_urgent),
    .nRAS       (n_ras),
    .nCASH      (n_cash),
    .nCASL      (n_casl),
    .RASMux     (ras_mux),
    .RAMReady   (ram_ready),
    .RefAck     (ref_ack),
    .Busy       (busy)
`ifdef RAM_REFSTAT_EN
    ,
    .RefCount   (ref_count),
    .UrgentCount(urgent_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {n_ras, n_cash, n_casl, ras_mux, ram_ready, ref_ack, busy};
  endfunction

  task automatic model_clear();
    sched.delete();
    in_acc = 1'b0;
`ifdef RAM_REFSTAT_EN
    m_ref_cnt = 0;
    m_urg_cnt = 0;
`endif
  endtask

  task automatic push_pre();
    for (int i = 0; i < int'(Pre); i++) sched.push_back(VPre);
    sched.push_back(VIdle);
  endtask

  // One clock: the model consumes the inputs seen at the edge and the outputs are compared.
  task automatic step();
    @(posedge fclk);
    #1;
    if (sched.size() != 0) begin
      exp_v = sched.pop_front();
    end else if (in_acc) begin
      if (as_inactive) begin
        push_pre();
        exp_v  = sched.pop_front();
        in_acc = 1'b0;
      end else begin
        exp_v = {1'b0, n_uds, n_lds, 4'b1101};
      end
    end else if (ref_urgent || (!(as_active && ramcs) && ref_req)) begin
      sched.push_back(VRcas);
      for (int i = 0; i < int'(Ref); i++) sched.push_back(i == 0 ? VRrasAk : VRras);
      push_pre();
      exp_v = sched.pop_front();
`ifdef RAM_REFSTAT_EN
      if (ref_urgent && m_urg_cnt < 255) m_urg_cnt++;
`endif
    end else if (as_active && ramcs) begin
      exp_v  = VRas;
      in_acc = 1'b1;
    end else begin
      exp_v = VIdle;
    end
`ifdef RAM_REFSTAT_EN
    if (exp_v[1] && m_ref_cnt < 65535) m_ref_cnt++;
`endif
    check("outputs", 32'(outs()), 32'(exp_v));
`ifdef RAM_REFSTAT_EN
    check("ref_count", 32'(ref_count), 32'(m_ref_cnt));
    check("urgent_count", 32'(urgent_count), 32'(m_urg_cnt));
`endif
  endtask

  task automatic set_idle_inputs();
    as_active   = 1'b0;
    as_inactive = 1'b1;
    ramcs       = 1'b0;
    n_uds       = 1'b1;
    n_lds       = 1'b1;
    ref_req     = 1'b0;
    ref_urgent  = 1'b0;
  endtask

  task automatic start_access(input logic u, input logic l);
    as_active   = 1'b1;
    as_inactive = 1'b0;
    ramcs       = 1'b1;
    n_uds       = u;
    n_lds       = l;
  endtask

  // Called just after an edge: reset lands mid-cycle and must act without a clock.
  task automatic do_reset();
    #2;
    n_reset = 1'b0;
    #1;
    check("rst_async", 32'({n_ras, n_cash, n_casl, ram_ready}), 32'(4'b1110));
    @(posedge fclk);
    #1;
    n_reset = 1'b1;
    model_clear();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_outs", 32'(outs()), 32'(VIdle));
  endtask

  initial begin
    int unsigned acks, ras_low, ready_at, bad_abort;
    bit as_state;

    n_reset = 1'b0;
    set_idle_inputs();
    model_clear();
    repeat (2) @(posedge fclk);
    #1;
    check("reset_outs", 32'(outs()), 32'(VIdle));
    n_reset = 1'b1;

    // Word read with timing checkpoints.
    start_access(1'b0, 1'b0);
    step();
    check("wr_ras_low", 32'(n_ras), 32'(0));
    step();
    check("wr_ready", 32'({ram_ready, n_cash, n_casl}), 32'(3'b100));
    repeat (3) step();
    set_idle_inputs();
    step();
    check("wr_strobes_high", 32'({n_ras, n_cash, n_casl}), 32'(3'b111));
    step();
    step();
    check("wr_busy_clear", 32'(busy), 32'(0));

    // Byte access: only the lower CAS strobe.
    start_access(1'b1, 1'b0);
    repeat (2) step();
    check("byte_cas", 32'({ram_ready, n_cash, n_casl}), 32'(3'b110));
    step();
    // Reset mid-HOLD.
    do_reset();

    // Idle refresh.
    set_idle_inputs();
    ref_req = 1'b1;
    step();
    check("ref_cbr", 32'({n_ras, n_cash, n_casl}), 32'(3'b100));
    ref_req = 1'b0;
    acks    = 0;
    ras_low = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ref_ack) acks++;
      if (!n_ras) ras_low++;
    end
    check("ref_ack_once", 32'(acks), 32'(1));
    check("ref_ras_len", 32'(ras_low), 32'(Ref));

    // Urgent refresh beats a pending access; access follows after refresh completes.
    start_access(1'b0, 1'b0);
    ref_urgent = 1'b1;
    step();
    check("urg_first", 32'({n_ras, n_cash}), 32'(2'b10));
    ref_urgent = 1'b0;
    ready_at   = 0;
    for (int i = 2; i < 20 && ready_at == 0; i++) begin
      step();
      if (ram_ready) ready_at = i;
    end
    check("urg_ready_cycle", 32'(ready_at), 32'(1 + Ref + Pre + 1 + 2));
    set_idle_inputs();
    repeat (Pre + 2) step();

    // Abort during RAS: no CAS, no ready, precharge before next RAS.
    start_access(1'b0, 1'b0);
    step();
    set_idle_inputs();
    bad_abort = 0;
    for (int i = 0; i < int'(Pre) + 2; i++) begin
      step();
      if (ram_ready || !n_cash || !n_casl) bad_abort++;
      if (i < int'(Pre) && !n_ras) bad_abort++;
    end
    check("abort_clean", 32'(bad_abort), 32'(0));

    // Randomised traffic with occasional mid-cycle resets.
    as_state = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) as_state = ~as_state;
      as_active   = as_state;
      as_inactive = ~as_state;
      ramcs       = ($urandom_range(3, 0) != 0);
      n_uds       = 1'($urandom);
      n_lds       = 1'($urandom);
      ref_req     = ($urandom_range(7, 0) == 0);
      ref_urgent  = ($urandom_range(31, 0) == 0);
      if (c % 500 == 499) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
